qinj_sequencer: RTL
===================

QINJ_SEQUENCER -- requirements
Module: qinj_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the pulse-count and interval fields.
REQ-002 SHALL have parameter DLY_W, default 6, width of the start-to-first-pulse delay field.
REQ-003 SHALL have parameter PW, default 2, injection pulse width in CLK40 cycles (legal range 1..15).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK40 and RSTn.
REQ-005 Ports SHALL be:
  - CLK40  in  1  40 MHz clock; all logic on the rising edge
  - RSTn  in  1  asynchronous active-low reset
  - QInjEn  in  1  global injection enable (config, quasi-static)
  - QInjStart  in  1  single-cycle start strobe from the fast-command decoder
  - QInjAbort  in  1  single-cycle abort strobe
  - QInjDelay  in  DLY_W  cycles from start to first pulse
  - QInjCount  in  CNT_W  number of pulses per burst
  - QInjInterval  in  CNT_W  low cycles between pulses
  - ChargeInj  out  1  registered pulse that drives the HTree ChargeInj input
  - Busy  out  1  high while a burst is in progress
  - Done  out  1  one-cycle strobe on burst completion
  - PulseCnt  out  CNT_W  pulses issued in the current or last burst

Function
REQ-006 SHALL implement states IDLE, DELAY, PULSE, GAP and FINISH.
REQ-007 In IDLE, QInjStart=1 with QInjEn=1 SHALL latch Delay/Count/Interval, clear PulseCnt, and enter DELAY next cycle; Busy SHALL rise that same next cycle.
REQ-008 QInjStart with QInjEn=0 SHALL be ignored.
REQ-009 QInjStart while Busy=1 SHALL be ignored; latched config SHALL remain unchanged.
REQ-010 With start sampled at edge 0, ChargeInj SHALL first rise at edge 1+QInjDelay; Delay=0 gives rise at edge 1.
REQ-011 ChargeInj SHALL stay high exactly PW cycles per pulse, driven directly from a flop (glitch-free).
REQ-012 PulseCnt SHALL increment on each ChargeInj rising edge and SHALL never wrap; at most QInjCount pulses are issued per burst.
REQ-013 After each pulse except the last, ChargeInj SHALL stay low max(QInjInterval,1) cycles (GAP) before the next rise.
REQ-014 After the last pulse falls, the FSM SHALL enter FINISH for one cycle: Done=1 and Busy=0 on that cycle, then return to IDLE.
REQ-015 QInjCount=0 SHALL produce no pulses: DELAY is still honoured, then FINISH with Done=1.
REQ-016 QInjAbort in any non-IDLE state SHALL force ChargeInj=0, Busy=0 and IDLE on the next edge, with no Done and PulseCnt holding its value.
REQ-017 Abort and start in the same IDLE cycle: abort SHALL win and no burst starts.
REQ-018 QInjEn falling mid-burst SHALL NOT affect the burst; only the start gate of REQ-007 uses it.
REQ-019 A start in the FINISH cycle SHALL be ignored; a start on the following IDLE cycle SHALL be accepted.

Reset
REQ-020 RSTn low SHALL asynchronously force state=IDLE, ChargeInj=0, Busy=0, Done=0, PulseCnt=0, and clear all counters and latched config.
REQ-021 Reset release SHALL be synchronised internally (two-flop release) so the first active edge after release is clean.
REQ-022 Reset asserted mid-pulse SHALL drop ChargeInj immediately, without waiting for a clock.

Structure
REQ-023 The state encoding enum and the PW/CNT_W/DLY_W defaults SHALL reside in the shared package qinj_pkg.
REQ-024 A single sub-module qinj_cycle_counter (loadable down-counter with zero flag) SHALL be reused for the DELAY, PULSE and GAP timing.
REQ-025 The block SHALL contain no combinational path from any input to ChargeInj.

Verification
REQ-026 Delay=3, Count=2, Interval=4, PW=2, start at edge 0 -> ChargeInj high at edges 4-5 and 10-11, Done at edge 12, PulseCnt=2.
REQ-027 Count=0, Delay=2 -> no ChargeInj, Busy edges 1-2, Done at edge 3, PulseCnt=0.
REQ-028 Count=5 with abort after the 2nd pulse -> ChargeInj=0 next cycle, no Done, PulseCnt=2, next start accepted.
REQ-029 Second start mid-burst and start with QInjEn=0 -> both ignored, burst timing identical to REQ-026.
REQ-030 RSTn pulsed low during a PULSE state -> ChargeInj falls asynchronously, all outputs 0, clean restart after release.
REQ-031 Interval=0, Count=3, PW=1 -> pulses separated by exactly 1 low cycle, Done one cycle after the third pulse.

Source files
------------

// File: rtl/qinj_pkg.sv
// qinj_pkg: shared state encoding and default widths for the charge-injection sequencer
package qinj_pkg;
   typedef enum logic [2:0] {IDLE, DELAY, PULSE, GAP, FINISH} qinj_state_e;
   localparam int CNT_W_DEF = 8;
   localparam int DLY_W_DEF = 6;
   localparam int PW_DEF    = 2;
   function automatic int max_w(int a, int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/qinj_cycle_counter.sv
// qinj_cycle_counter: loadable down-counter that saturates at zero and flags it
module qinj_cycle_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign zero = cnt == '0;
endmodule

// File: rtl/qinj_sequencer.sv
// qinj_sequencer: burst generator for the HTree ChargeInj line (delay, N pulses of PW cycles, gaps)
module qinj_sequencer
   import qinj_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DLY_W = DLY_W_DEF,
   parameter int PW    = PW_DEF
) (
   input  logic             CLK40,
   input  logic             RSTn,
   input  logic             QInjEn,
   input  logic             QInjStart,
   input  logic             QInjAbort,
   input  logic [DLY_W-1:0] QInjDelay,
   input  logic [CNT_W-1:0] QInjCount,
   input  logic [CNT_W-1:0] QInjInterval,
   output logic             ChargeInj,
   output logic             Busy,
   output logic             Done,
   output logic [CNT_W-1:0] PulseCnt
);
   localparam int TW = max_w(max_w(CNT_W, DLY_W), 4);
   qinj_state_e state, nxt;
   logic [1:0] rst_sync;
   logic rst_n_i;
   logic [CNT_W-1:0] cnt_l, int_l;
   logic tmr_load, tmr_zero;
   logic [TW-1:0] tmr_val, gap_len;
   logic charge_d, busy_d, done_d;
   // assertion is immediate, release only after two clean edges
   always_ff @(posedge CLK40 or negedge RSTn)
      if (!RSTn) rst_sync <= '0;
      else rst_sync <= {rst_sync[0], 1'b1};
   assign rst_n_i = rst_sync[1];
   always_ff @(posedge CLK40 or negedge rst_n_i)
      if (!rst_n_i) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (QInjStart && QInjEn) ? DELAY : IDLE;
         DELAY:   if (tmr_zero) nxt = (cnt_l == '0) ? FINISH : PULSE;
         PULSE:   if (tmr_zero) nxt = (PulseCnt == cnt_l) ? FINISH : GAP;
         GAP:     if (tmr_zero) nxt = PULSE;
         FINISH:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (QInjAbort) nxt = IDLE;
   end
   // every state entry reloads the shared timer with (length - 1)
   always_comb begin
      gap_len  = (int_l == '0) ? '0 : TW'(int_l) - TW'(1);
      tmr_load = nxt != state;
      tmr_val  = nxt == DELAY ? TW'(QInjDelay) : nxt == PULSE ? TW'(PW - 1) : nxt == GAP ? gap_len : '0;
      charge_d = nxt == PULSE;
      busy_d   = nxt inside {DELAY, PULSE, GAP};
      done_d   = nxt == FINISH;
   end
   qinj_cycle_counter #(.W(TW)) u_tmr (
      .clk(CLK40),
      .rst_n(rst_n_i),
      .load(tmr_load),
      .load_val(tmr_val),
      .zero(tmr_zero)
   );
   always_ff @(posedge CLK40 or negedge rst_n_i)
      if (!rst_n_i) begin
         ChargeInj <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         PulseCnt  <= '0;
         cnt_l     <= '0;
         int_l     <= '0;
      end else begin
         ChargeInj <= charge_d;
         Busy      <= busy_d;
         Done      <= done_d;
         if (state == IDLE && nxt == DELAY) begin
            cnt_l    <= QInjCount;
            int_l    <= QInjInterval;
            PulseCnt <= '0;
         end else if (charge_d && state != PULSE) PulseCnt <= PulseCnt + CNT_W'(1);
      end
endmodule
